iq_mixer_cic: RTL and testbench



---
 rtl/iq_mixer_cic.sv | 144 ++++++++++++++
 tb/tb_iq_mixer_cic.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_mixer_cic.sv
// 1-bit RF x 1-bit LO quadrature mixer feeding a 3-stage CIC decimator per branch.
// Output strobe lands 4 cycles after the decimation tick; free-running, no backpressure.
module iq_mixer_cic #(
  parameter int LOG2_DECIM = 12,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        rf_in,
  input  logic                        sin_in,
  input  logic                        cos_in,
  output logic signed [OUT_WIDTH-1:0] i_out,
  output logic signed [OUT_WIDTH-1:0] q_out,
  output logic                        out_valid
);

  localparam int ACC_WIDTH = 2 + 3 * LOG2_DECIM;
  localparam int SHIFT     = ACC_WIDTH - OUT_WIDTH;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic [LOG2_DECIM-1:0]       cnt_q, cnt_d;
  logic [3:0]                  vld_q, vld_d;
  logic signed [1:0]           mix_q [2];
  logic signed [1:0]           mix_d [2];
  acc_t                        int1_q [2];
  acc_t                        int1_d [2];
  acc_t                        int2_q [2];
  acc_t                        int2_d [2];
  acc_t                        int3_q [2];
  acc_t                        int3_d [2];
  acc_t                        samp_q [2];
  acc_t                        samp_d [2];
  acc_t                        samp_prev_q [2];
  acc_t                        samp_prev_d [2];
  acc_t                        c1_q [2];
  acc_t                        c1_d [2];
  acc_t                        c1_prev_q [2];
  acc_t                        c1_prev_d [2];
  acc_t                        c2_q [2];
  acc_t                        c2_d [2];
  acc_t                        c2_prev_q [2];
  acc_t                        c2_prev_d [2];
  acc_t                        comb3 [2];
  logic signed [OUT_WIDTH-1:0] out_q [2];
  logic signed [OUT_WIDTH-1:0] out_d [2];
  logic [1:0]                  lo;
  logic                        dec_tick;

  // Branch 0 is I (mixed with cos), branch 1 is Q (mixed with sin).
  assign lo       = {sin_in, cos_in};
  assign dec_tick = (cnt_q == '1);

  always_comb begin
    cnt_d = cnt_q + LOG2_DECIM'(1);
    vld_d = {vld_q[2:0], dec_tick};
    for (int b = 0; b < 2; b++) begin
      mix_d[b]       = (rf_in == lo[b]) ? 2'sb01 : 2'sb11;
      int1_d[b]      = int1_q[b] + acc_t'(mix_q[b]);
      int2_d[b]      = int2_q[b] + int1_q[b];
      int3_d[b]      = int3_q[b] + int2_q[b];
      samp_d[b]      = dec_tick ? int3_q[b] : samp_q[b];
      samp_prev_d[b] = samp_prev_q[b];
      c1_d[b]        = c1_q[b];
      c1_prev_d[b]   = c1_prev_q[b];
      c2_d[b]        = c2_q[b];
      c2_prev_d[b]   = c2_prev_q[b];
      out_d[b]       = out_q[b];
      comb3[b]       = c2_q[b] - c2_prev_q[b];
      // Each comb delay advances only on its own stage strobe (M=1 at the decimated rate).
      if (vld_q[0]) begin
        c1_d[b]        = samp_q[b] - samp_prev_q[b];
        samp_prev_d[b] = samp_q[b];
      end
      if (vld_q[1]) begin
        c2_d[b]      = c1_q[b] - c1_prev_q[b];
        c1_prev_d[b] = c1_q[b];
      end
      if (vld_q[2]) begin
        out_d[b]     = OUT_WIDTH'(comb3[b] >>> SHIFT);
        c2_prev_d[b] = c2_q[b];
      end
    end
    if (!en) begin
      cnt_d = '0;
      vld_d = '0;
      for (int b = 0; b < 2; b++) begin
        mix_d[b]       = '0;
        int1_d[b]      = '0;
        int2_d[b]      = '0;
        int3_d[b]      = '0;
        samp_d[b]      = '0;
        samp_prev_d[b] = '0;
        c1_d[b]        = '0;
        c1_prev_d[b]   = '0;
        c2_d[b]        = '0;
        c2_prev_d[b]   = '0;
        out_d[b]       = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vld_q <= '0;
      for (int b = 0; b < 2; b++) begin
        mix_q[b]       <= '0;
        int1_q[b]      <= '0;
        int2_q[b]      <= '0;
        int3_q[b]      <= '0;
        samp_q[b]      <= '0;
        samp_prev_q[b] <= '0;
        c1_q[b]        <= '0;
        c1_prev_q[b]   <= '0;
        c2_q[b]        <= '0;
        c2_prev_q[b]   <= '0;
        out_q[b]       <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      for (int b = 0; b < 2; b++) begin
        mix_q[b]       <= mix_d[b];
        int1_q[b]      <= int1_d[b];
        int2_q[b]      <= int2_d[b];
        int3_q[b]      <= int3_d[b];
        samp_q[b]      <= samp_d[b];
        samp_prev_q[b] <= samp_prev_d[b];
        c1_q[b]        <= c1_d[b];
        c1_prev_q[b]   <= c1_prev_d[b];
        c2_q[b]        <= c2_d[b];
        c2_prev_q[b]   <= c2_prev_d[b];
        out_q[b]       <= out_d[b];
      end
    end
  end

  assign i_out     = out_q[0];
  assign q_out     = out_q[1];
  assign out_valid = vld_q[3];

endmodule

// File: tb/tb_iq_mixer_cic.sv
// Directed bench for iq_mixer_cic at R=64: gain, period, wrap, en-drop, async reset,
// and a random bitstream checked against a direct 3rd-order boxcar convolution.
module tb_iq_mixer_cic;

  localparam int L   = 6;
  localparam int R   = 64;
  localparam int ACC = 2 + 3 * L;
  localparam int OW  = 16;
  localparam int NT  = 3 * R - 2;
  localparam int XN  = 4096;

  logic                 clk = 1'b0;
  logic                 rst_n, en, rf_in, sin_in, cos_in;
  logic signed [OW-1:0] i_out, q_out;
  logic                 out_valid;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         mode  = 0;
  int         prev  = 0;
  logic [3:0] ph    = 4'd0;
  int         xi [XN];
  int         xq [XN];
  int         h2 [2*R-1];
  int         h3 [NT];

  always #5 clk = ~clk;

  iq_mixer_cic #(.LOG2_DECIM(L), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rf_in     (rf_in),
    .sin_in    (sin_in),
    .cos_in    (cos_in),
    .i_out     (i_out),
    .q_out     (q_out),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // LO is a period-16 square pair; mode picks the RF stream.
  task automatic drive();
    logic [3:0] p4;
    ph     = ph + 4'd1;
    p4     = ph + 4'd4;
    sin_in = ph[3];
    cos_in = p4[3];
    case (mode)
      1:       rf_in = ~cos_in;
      2:       rf_in = sin_in;
      3:       begin sin_in = 1'b0; cos_in = 1'b0; rf_in = 1'b0; end
      4:       rf_in = 1'($urandom_range(0, 1));
      default: rf_in = cos_in;
    endcase
    if (cyc >= 0 && cyc < XN) begin
      xi[cyc] = (rf_in == cos_in) ? 1 : -1;
      xq[cyc] = (rf_in == sin_in) ? 1 : -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic wait_strobe(input int limit);
    int n = 0;
    do begin
      step();
      n++;
    end while (out_valid !== 1'b1 && n < limit);
    if (out_valid !== 1'b1) chk("strobe_timeout", int'(out_valid), 1);
  endtask

  task automatic skip(input int n);
    for (int k = 0; k < n; k++) wait_strobe(R + 8);
  endtask

  task automatic check_strobes(input string tag, input int n, input int ei, input int eq);
    for (int k = 0; k < n; k++) begin
      wait_strobe(R + 8);
      chk({tag, "_i"}, i_out, ei);
      chk({tag, "_q"}, q_out, eq);
    end
  endtask

  // Strobe visible in cycle s comes from tick T=s-4, whose window ends at input cycle T-4.
  function automatic int model_out(input int s, input bit qb);
    longint               acc = 0;
    logic [ACC-1:0]       a;
    logic signed [OW-1:0] o;
    for (int j = 0; j < NT; j++) begin
      int idx;
      idx = s - 8 - j;
      if (idx >= 0) acc += longint'(h3[j] * (qb ? xq[idx] : xi[idx]));
    end
    a = acc[ACC-1:0];
    o = a[ACC-1 -: OW];
    return int'(o);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 2*R-1; n++) begin
      h2[n] = 0;
      for (int a = 0; a < R; a++) if (n - a >= 0 && n - a < R) h2[n]++;
    end
    for (int n = 0; n < NT; n++) begin
      h3[n] = 0;
      for (int a = 0; a < R; a++) if (n - a >= 0 && n - a < 2*R-1) h3[n] += h2[n-a];
    end

    rst_n = 1'b0; en = 1'b0; rf_in = 1'b0; sin_in = 1'b0; cos_in = 1'b0;
    #3;
    chk("reset_i", i_out, 0);
    chk("reset_q", q_out, 0);
    chk("reset_vld", int'(out_valid), 0);
    step();
    step();

    // Test 1: rf = cos, steady I = +2^14, Q = 0; first strobe at cycle R+3.
    mode = 0;
    en = 1'b1; rst_n = 1'b1; cyc = 0; drive();
    wait_strobe(R + 8);
    chk("t1_first_cyc", cyc, R + 3);
    prev = cyc;
    step();
    chk("t1_pulse_width", int'(out_valid), 0);
    for (int k = 1; k < 7; k++) begin
      wait_strobe(R + 8);
      chk("t1_period", cyc - prev, R);
      prev = cyc;
      if (k >= 4) begin
        chk("t1_i", i_out, 16384);
        chk("t1_q", q_out, 0);
      end
    end

    // Test 2: inverted cos, then rf = sin.
    mode = 1;
    skip(4);
    check_strobes("t2_inv", 2, -16384, 0);
    mode = 2;
    skip(4);
    check_strobes("t2_sin", 2, 0, 16384);

    // Test 3: constant +1 on both branches for ~10000 cycles; integrators wrap repeatedly.
    mode = 3;
    for (int k = 0; k < 156; k++) begin
      wait_strobe(R + 8);
      if (k >= 4) begin
        chk("t3_i", i_out, 16384);
        chk("t3_q", q_out, 16384);
      end
    end

    // Test 4: en low for exactly the tick cycle (counter = R-1, 60 cycles after a strobe).
    mode = 0;
    repeat (R - 4) step();
    en = 1'b0;
    step();
    en = 1'b1; cyc = 0; drive();
    chk("t4_clr_i", i_out, 0);
    chk("t4_clr_q", q_out, 0);
    chk("t4_clr_vld", int'(out_valid), 0);
    wait_strobe(R + 8);
    chk("t4_first_cyc", cyc, R + 3);
    skip(3);
    check_strobes("t4_steady", 2, 16384, 0);

    // Test 5: async reset mid-cycle with counter = 37 (strobe cycle has counter 3).
    repeat (34) step();
    chk("t5_pre_i", i_out, 16384);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_i", i_out, 0);
    chk("t5_async_q", q_out, 0);
    chk("t5_async_vld", int'(out_valid), 0);
    step();
    step();
    rst_n = 1'b1; cyc = 0; drive();
    wait_strobe(R + 8);
    chk("t5_first_cyc", cyc, R + 3);
    skip(3);
    check_strobes("t5_steady", 2, 16384, 0);

    // Test 6: random RF from a clean start, 50 samples against the convolution model.
    mode = 4;
    en = 1'b0;
    step();
    en = 1'b1; cyc = 0; drive();
    for (int k = 0; k < 54; k++) begin
      wait_strobe(R + 8);
      if (k >= 4) begin
        chk("t6_rand_i", i_out, model_out(cyc, 1'b0));
        chk("t6_rand_q", q_out, model_out(cyc, 1'b1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
